// File: rtl/reg_bank_pkg.sv
// Shared defaults and port-slicing helper for the multi-read-port register bank.
package reg_bank_pkg;

    localparam int REG_BANK_DATA_W = 32;
    localparam int REG_BANK_DEPTH  = 32;
    localparam int REG_BANK_NUM_RD = 2;

    // Base bit index of port p inside a flattened bus of w-bit fields.
    function automatic int rd_slice(input int p, input int w);
        return p * w;
    endfunction

endpackage

// File: rtl/reg_rd_mux.sv
// DEPTH:1 word selector feeding one read-port output register; combinational only.
module reg_rd_mux #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 32,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][DATA_W-1:0] words,
    input  logic [ADDR_W-1:0]            sel,
    output logic [DATA_W-1:0]            word
);

    // DEPTH is a power of two, so every sel value names a real entry.
    assign word = words[sel];

endmodule

// File: rtl/reg_bank_mrp.sv
// Register bank: one write port, NUM_RD registered read ports with write-first
// bypass and an optional hardwired-zero entry 0.
module reg_bank_mrp
    import reg_bank_pkg::*;
#(
    parameter  int DATA_W  = REG_BANK_DATA_W,
    parameter  int DEPTH   = REG_BANK_DEPTH,
    parameter  int NUM_RD  = REG_BANK_NUM_RD,
    parameter  int ZERO_R0 = 1,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic                     wr_ack
);

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic                         wr_to_zero;

    assign wr_to_zero = (ZERO_R0 != 0) && (wr_addr == '0);

    // Writes to a hardwired-zero entry are dropped but still acknowledged.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '0;
            wr_ack <= 1'b0;
        end else begin
            wr_ack <= wr_en;
            if (wr_en && !wr_to_zero)
                mem[wr_addr] <= wr_data;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] mux_word;
        logic [DATA_W-1:0] rd_next;
        logic [DATA_W-1:0] data_q;
        logic              vld_q;

        assign addr = rd_addr[rd_slice(p, ADDR_W) +: ADDR_W];

        reg_rd_mux #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_mux (
            .words (mem),
            .sel   (addr),
            .word  (mux_word)
        );

        // Write-first bypass, then the zero entry overrides everything.
        always_comb begin
            rd_next = mux_word;
            if (wr_en && (addr == wr_addr))
                rd_next = wr_data;
            if ((ZERO_R0 != 0) && (addr == '0))
                rd_next = '0;
        end

        // Data holds when the port is idle; only valid drops.
        always_ff @(posedge clk) begin
            if (rst) begin
                data_q <= '0;
                vld_q  <= 1'b0;
            end else begin
                vld_q <= rd_en[p];
                if (rd_en[p])
                    data_q <= rd_next;
            end
        end

        assign rd_data[rd_slice(p, DATA_W) +: DATA_W] = data_q;
        assign rd_valid[p]                            = vld_q;
    end

endmodule

// File: tb/tb_reg_bank_mrp.sv
// Directed bench for reg_bank_mrp: three configurations checked against a
// reference model through an expectation queue drained one cycle after drive.
module tb_reg_bank_mrp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // A: defaults, ZERO_R0=1
    logic        a_wr_en = 0;
    logic [4:0]  a_wr_addr = '0;
    logic [31:0] a_wr_data = '0;
    logic [1:0]  a_rd_en = '0;
    logic [9:0]  a_rd_addr = '0;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_valid;
    logic        a_wr_ack;
    // B: defaults, ZERO_R0=0
    logic        b_wr_en = 0;
    logic [4:0]  b_wr_addr = '0;
    logic [31:0] b_wr_data = '0;
    logic [1:0]  b_rd_en = '0;
    logic [9:0]  b_rd_addr = '0;
    logic [63:0] b_rd_data;
    logic [1:0]  b_rd_valid;
    logic        b_wr_ack;
    // C: DATA_W=8, DEPTH=4, NUM_RD=3
    logic        c_wr_en = 0;
    logic [1:0]  c_wr_addr = '0;
    logic [7:0]  c_wr_data = '0;
    logic [2:0]  c_rd_en = '0;
    logic [5:0]  c_rd_addr = '0;
    logic [23:0] c_rd_data;
    logic [2:0]  c_rd_valid;
    logic        c_wr_ack;

    reg_bank_mrp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .ZERO_R0(1)) u_a (
        .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
        .wr_ack(a_wr_ack));
    reg_bank_mrp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .ZERO_R0(0)) u_b (
        .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .wr_ack(b_wr_ack));
    reg_bank_mrp #(.DATA_W(8), .DEPTH(4), .NUM_RD(3), .ZERO_R0(1)) u_c (
        .clk(clk), .rst(rst), .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
        .rd_en(c_rd_en), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_valid(c_rd_valid),
        .wr_ack(c_wr_ack));

    typedef struct {
        int          d;    // dut 0/1/2
        int          k;    // 0 data, 1 valid, 2 ack
        int          p;
        logic [31:0] v;
        string       tag;
    } exp_t;

    exp_t        sbq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mdl  [3][32];
    logic [31:0] hold [3][3];
    int          np   [3] = '{2, 2, 3};
    int          zr   [3] = '{1, 0, 1};
    int          amsk [3] = '{31, 31, 3};
    logic [31:0] dmsk [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};

    function automatic logic [31:0] observe(input int d, input int k, input int p);
        logic [31:0] r;
        r = 'x;
        case (d)
            0: r = (k == 0) ? a_rd_data[p*32 +: 32] : (k == 1) ? {31'b0, a_rd_valid[p]} : {31'b0, a_wr_ack};
            1: r = (k == 0) ? b_rd_data[p*32 +: 32] : (k == 1) ? {31'b0, b_rd_valid[p]} : {31'b0, b_wr_ack};
            default: r = (k == 0) ? {24'b0, c_rd_data[p*8 +: 8]} : (k == 1) ? {31'b0, c_rd_valid[p]} : {31'b0, c_wr_ack};
        endcase
        return r;
    endfunction

    task automatic push(input int d, input int k, input int p, input logic [31:0] v, input string tag);
        exp_t e;
        e.d = d; e.k = k; e.p = p; e.v = v; e.tag = tag;
        sbq.push_back(e);
    endtask

    // Advance one edge, then drain every expectation queued for it.
    task automatic tick();
        exp_t        e;
        logic [31:0] o;
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            o = observe(e.d, e.k, e.p);
            n_cmp++;
            assert (o === e.v) else begin
                n_bad++;
                $error("FAIL %s dut%0d kind%0d port%0d: observed %h expected %h",
                       e.tag, e.d, e.k, e.p, o, e.v);
            end
        end
    endtask

    task automatic idle_all();
        a_wr_en = 0; a_rd_en = '0;
        b_wr_en = 0; b_rd_en = '0;
        c_wr_en = 0; c_rd_en = '0;
    endtask

    task automatic reset_all(input string tag);
        rst = 1'b1;
        a_wr_en = 1; a_rd_en = '1;
        b_wr_en = 1; b_rd_en = '1;
        c_wr_en = 1; c_rd_en = '1;
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 32; i++) mdl[d][i] = '0;
            for (int p = 0; p < np[d]; p++) begin
                hold[d][p] = '0;
                push(d, 0, p, 32'h0, tag);
                push(d, 1, p, 32'h0, tag);
            end
            push(d, 2, 0, 32'h0, tag);
        end
        tick();
        rst = 1'b0;
        idle_all();
    endtask

    task automatic step(input int d, input bit we, input int wa_i, input logic [31:0] wd_i,
                        input logic [2:0] re, input int a0, input int a1, input int a2,
                        input string tag);
        int          ad[3];
        int          wa;
        logic [31:0] wd;
        logic [31:0] e;
        idle_all();
        wa = wa_i & amsk[d];
        wd = wd_i & dmsk[d];
        ad[0] = a0 & amsk[d]; ad[1] = a1 & amsk[d]; ad[2] = a2 & amsk[d];
        case (d)
            0: begin
                a_wr_en = we; a_wr_addr = wa[4:0]; a_wr_data = wd;
                a_rd_en = re[1:0]; a_rd_addr = {ad[1][4:0], ad[0][4:0]};
            end
            1: begin
                b_wr_en = we; b_wr_addr = wa[4:0]; b_wr_data = wd;
                b_rd_en = re[1:0]; b_rd_addr = {ad[1][4:0], ad[0][4:0]};
            end
            default: begin
                c_wr_en = we; c_wr_addr = wa[1:0]; c_wr_data = wd[7:0];
                c_rd_en = re; c_rd_addr = {ad[2][1:0], ad[1][1:0], ad[0][1:0]};
            end
        endcase
        for (int p = 0; p < np[d]; p++) begin
            if (re[p]) begin
                if (zr[d] != 0 && ad[p] == 0) e = '0;
                else if (we && wa == ad[p])   e = wd;
                else                          e = mdl[d][ad[p]];
                hold[d][p] = e;
                push(d, 1, p, 32'h1, tag);
            end else begin
                push(d, 1, p, 32'h0, tag);
            end
            push(d, 0, p, hold[d][p], tag);
        end
        push(d, 2, 0, {31'b0, we}, tag);
        if (we && !(zr[d] != 0 && wa == 0)) mdl[d][wa] = wd;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_all();
        reset_all("reset_init");

        // reset clears stored data
        step(0, 1, 5, 32'hDEAD_BEEF, 3'b000, 0, 0, 0, "wr_r5");
        reset_all("reset_mid");
        step(0, 0, 0, 0, 3'b001, 5, 0, 0, "rd_r5_after_rst");

        // basic write then read on port 1
        step(0, 1, 7, 32'h1234_5678, 3'b000, 0, 0, 0, "wr_r7");
        step(0, 0, 0, 0, 3'b010, 0, 7, 0, "rd_r7_p1");
        step(0, 0, 0, 0, 3'b000, 0, 0, 0, "ack_drop");

        // bypass on both ports; r9 is still 0 beforehand
        step(0, 0, 0, 0, 3'b011, 9, 9, 0, "rd_r9_old");
        step(0, 1, 9, 32'hA5A5_A5A5, 3'b011, 9, 9, 0, "bypass_r9");
        step(0, 0, 0, 0, 3'b011, 9, 7, 0, "rd_r9_r7");

        // hardwired zero vs ordinary entry 0
        step(0, 1, 0, 32'hFFFF_FFFF, 3'b000, 0, 0, 0, "a_wr_r0");
        step(0, 0, 0, 0, 3'b011, 0, 0, 0, "a_rd_r0");
        step(0, 1, 0, 32'hFFFF_FFFF, 3'b001, 0, 0, 0, "a_bypass_r0");
        step(1, 1, 0, 32'hFFFF_FFFF, 3'b000, 0, 0, 0, "b_wr_r0");
        step(1, 0, 0, 0, 3'b011, 0, 0, 0, "b_rd_r0");
        step(1, 1, 0, 32'h0BAD_F00D, 3'b010, 0, 0, 0, "b_bypass_r0");

        // hold/valid: one read, then idle while r3 is rewritten
        step(0, 1, 3, 32'h11, 3'b000, 0, 0, 0, "wr_r3");
        step(0, 0, 0, 0, 3'b001, 3, 0, 0, "rd_r3");
        for (int i = 0; i < 3; i++)
            step(0, 1, 3, 32'h22, 3'b000, 3, 3, 0, "hold_r3");
        step(0, 0, 0, 0, 3'b001, 3, 0, 0, "rd_r3_new");

        // small configuration: fill, then concurrent distinct reads
        for (int i = 0; i < 4; i++)
            step(2, 1, i, 32'h10 + i, 3'b000, 0, 0, 0, "c_fill");
        step(2, 0, 0, 0, 3'b111, 3, 1, 2, "c_rd_312");
        step(2, 0, 0, 0, 3'b111, 0, 7, 5, "c_rd_wrap");
        step(2, 1, 2, 32'h1AB, 3'b101, 2, 1, 2, "c_bypass");

        // reset in the middle of reads and a write
        step(0, 1, 4, 32'h44, 3'b011, 7, 9, 0, "pre_rst");
        reset_all("rst_drop");
        step(0, 0, 0, 0, 3'b011, 7, 4, 0, "post_rst");

        for (int i = 0; i < 40; i++)
            step(2, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $urandom,
                 3'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), "c_rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_bank_mrp.md
Name: reg_bank_mrp

Overview:
Parametrised register bank with one write port and NUM_RD read ports. It generalises the fixed 32-entry, 1-bit select tree to arbitrary data width, depth and read-port count. Each read port is registered and has an enable/valid handshake, a same-cycle write-to-read bypass and an optional hardwired-zero entry 0. It is the register-file core of the team's datapath and replaces per-bit hand-instantiated mux trees.

Parameters:
DATA_W, 32, width of each register in bits (>=1)
DEPTH, 32, number of registers; power of two, >=2
ADDR_W, $clog2(DEPTH), address width (derived; must not be overridden)
NUM_RD, 2, number of independent read ports (1..4)
ZERO_R0, 1, 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is an ordinary register

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
wr_en  input  1  write strobe
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
rd_en  input  NUM_RD  per-port read request
rd_addr  input  NUM_RD*ADDR_W  port p address at bits [p*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  port p data at bits [p*DATA_W +: DATA_W]
rd_valid  output  NUM_RD  per-port: rd_data for that port is valid this cycle
wr_ack  output  1  high one cycle after an accepted write

Behaviour:
- Reset: all DEPTH entries clear to 0 in the reset cycle. rd_data = 0, rd_valid = 0, wr_ack = 0. rst overrides wr_en and rd_en in the same cycle.
- Write: on a rising edge with wr_en=1 and rst=0, mem[wr_addr] <= wr_data, and wr_ack = 1 in the next cycle.
  - If ZERO_R0=1 and wr_addr=0, the write is discarded but wr_ack is still asserted, so the handshake stays uniform.
- Read latency is 1 cycle. At edge N with rd_en[p]=1:
  - rd_data[p] <= selected value;
  - rd_valid[p] <= 1 during cycle N+1.
- With rd_en[p]=0, rd_valid[p] <= 0 and rd_data[p] holds its previous value. It is not cleared.
- Bypass (write-first): if wr_en=1, rd_en[p]=1 and rd_addr[p]==wr_addr at the same edge, rd_data[p] <= wr_data. The ZERO_R0 rule wins: address 0 with ZERO_R0=1 always returns 0.
- Multiple ports may read the same address in the same cycle, and each gets an identical result. There are no port conflicts and no stalls.
- Out-of-range addresses cannot occur because DEPTH is a power of two. Every address wraps naturally within ADDR_W.
- Reset mid-operation: a read issued in the rst cycle produces rd_valid=0 in the following cycle. The pending wr_ack is dropped.
- Selection is a DEPTH:1 DATA_W-wide mux per port. It is purely combinational in front of the output register.
- No combinational path exists from any input to any output.

Decomposition:
- Package reg_bank_pkg:
  - defaults REG_BANK_DATA_W=32, REG_BANK_DEPTH=32, REG_BANK_NUM_RD=2;
  - helper function for port slicing, rd_slice(p, w) returning the base index.
- Sub-module reg_rd_mux (params DATA_W, DEPTH), one instance per read port:
  - generic DEPTH:1 selector of DATA_W-bit words;
  - built as a tree or a case statement;
  - combinational only.
- reg_bank_mrp owns the storage, write logic, bypass compare, zero-entry logic and the output/valid registers.

Test Plan:
- Reset clears: write 0xDEADBEEF to r5, assert rst 1 cycle, read r5 on port 0 -> next cycle rd_data=0x00000000, rd_valid[0]=1.
- Basic write/read: write r7=0x12345678 at cycle 1, rd_en[1]=1 with rd_addr=7 at cycle 2 -> cycle 3 rd_data[1]=0x12345678, rd_valid[1]=1; wr_ack=1 in cycle 2 only.
- Bypass: same edge wr_en=1 wr_addr=9 wr_data=0xA5A5A5A5, rd_en=2'b11 with both ports addressing 9 -> both ports return 0xA5A5A5A5 next cycle, while the old r9 value is 0.
- Zero register: with ZERO_R0=1, write r0=0xFFFFFFFF then read r0 -> 0x00000000 with wr_ack=1; with ZERO_R0=0, the same sequence returns 0xFFFFFFFF.
- Hold/valid: rd_en[0] high 1 cycle on r3=0x11, then low 3 cycles while r3 is rewritten to 0x22 -> rd_valid[0] pulses once and rd_data[0] stays 0x11.
- Parameter sweep: DATA_W=8, DEPTH=4, NUM_RD=3 -> write all 4 entries (0x10..0x13), read all ports concurrently with distinct addresses including wrap (addr 3) -> every port matches the model.
